// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the register-file write-back arbiter.
package wb_pkg;

   localparam int WB_NUM_REGS  = 32;
   localparam int WB_ADDR_W    = $clog2(WB_NUM_REGS);
   localparam int WB_DATA_W    = 32;
   localparam int WB_ZERO_REG  = 0;
   localparam int WB_MAX_N_REQ = 8;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: valid/ready write-back bus from N_REQ producers.
// Per-producer fields are packed side by side, producer i at slice i.
interface regfile_wb_arbiter_if
   import wb_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*ADDR_W-1:0] req_reg;
   logic [N_REQ*DATA_W-1:0] req_data;

   // Producers drive the request and watch ready.
   modport master (output req_valid, output req_reg, output req_data, input req_ready);

   // The arbiter consumes the request and drives ready.
   modport slave (input req_valid, input req_reg, input req_data, output req_ready);

endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: picks one requester, returning a one-hot grant and its index.
// With WB_RR_EN defined the search starts one past the last grant and a
// pointer register tracks that grant; otherwise index 0 has fixed priority
// and the block is purely combinational.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int N = 3
) (
`ifdef WB_RR_EN
   input  logic                 clk,
   input  logic                 reset_n,
`endif
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(N);

`ifdef WB_RR_EN
   logic [IDX_W-1:0] ptr;

   // Search the requesters starting one past the last granted index.
   always_comb begin
      logic [IDX_W-1:0] cand;
      logic             found;
      // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Remember the last grant; an idle cycle leaves the pointer alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= IDX_W'(N - 1);
      end else if (|req) begin
         ptr <= grant_idx;
      end
   end
`else
   // Fixed priority: the lowest requesting index wins.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: buffers one write-back per producer, grants one per
// cycle onto the register file's single write port from registered outputs,
// and flags decode reads that hit a write still in flight.
// Build option: WB_RR_EN selects round-robin instead of fixed priority.
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   regfile_wb_arbiter_if.slave      wb,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic [$clog2(N_REQ)-1:0] rf_wsrc,
   input  logic [ADDR_W-1:0]        chk_reg1,
   input  logic [ADDR_W-1:0]        chk_reg2,
   output logic                     hazard1,
   output logic                     hazard2,
   output logic                     busy
);

   localparam int               IDX_W    = $clog2(N_REQ);
   localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(WB_ZERO_REG);

   logic [N_REQ-1:0]  buf_v;
   logic [ADDR_W-1:0] buf_reg  [N_REQ];
   logic [DATA_W-1:0] buf_data [N_REQ];

   logic [N_REQ-1:0]  grant;
   logic [IDX_W-1:0]  grant_idx;
   logic [N_REQ-1:0]  accept;
   logic [N_REQ-1:0]  keep;
   logic [ADDR_W-1:0] win_reg;
   logic [DATA_W-1:0] win_data;

   wb_rr_arbiter #(.N(N_REQ)) u_arb (
`ifdef WB_RR_EN
      .clk       (clk),
      .reset_n   (reset_n),
`endif
      .req       (buf_v),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // A slot can take a new request when empty or when it drains this edge.
   assign wb.req_ready = {N_REQ{reset_n}} & (~buf_v | grant);
   assign accept       = wb.req_valid & wb.req_ready;

   // Writes to register 0 complete the handshake but are dropped here.
   always_comb begin
      keep = '0;
      for (int i = 0; i < N_REQ; i++) begin
         keep[i] = wb.req_reg[i*ADDR_W +: ADDR_W] != ZERO_REG;
      end
   end

   // Slot occupancy: clear on grant, set on a kept acceptance (refill wins).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         buf_v <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
               buf_v[i] <= 1'b0;
            end
            if (accept[i] && keep[i]) begin
               buf_v[i] <= 1'b1;
            end
         end
      end
   end

   // Slot payload capture on a kept acceptance.
   // NOTE: payload storage has no reset; buf_v alone qualifies it, so stale contents are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (accept[i] && keep[i]) begin
            buf_reg[i]  <= wb.req_reg[i*ADDR_W +: ADDR_W];
            buf_data[i] <= wb.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Select the granted slot's payload.
   always_comb begin
      win_reg  = '0;
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            win_reg  = buf_reg[i];
            win_data = buf_data[i];
         end
      end
   end

   // Register-file write port; data outputs hold across idle cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rf_wsrc  <= '0;
      end else begin
         rf_we <= |buf_v;
         if (|buf_v) begin
            rf_waddr <= win_reg;
            rf_wdata <= win_data;
            rf_wsrc  <= grant_idx;
         end
      end
   end

   // Decode hazards against buffered writes and the write on the port.
   always_comb begin
      hazard1 = rf_we && (rf_waddr == chk_reg1);
      hazard2 = rf_we && (rf_waddr == chk_reg2);
      for (int i = 0; i < N_REQ; i++) begin
         if (buf_v[i] && (buf_reg[i] == chk_reg1)) hazard1 = 1'b1;
         if (buf_v[i] && (buf_reg[i] == chk_reg2)) hazard2 = 1'b1;
      end
      if (chk_reg1 == ZERO_REG) hazard1 = 1'b0;
      if (chk_reg2 == ZERO_REG) hazard2 = 1'b0;
   end

   assign busy = (|buf_v) | rf_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table, hand-written multi-cycle
// sequences (contention, back-to-back, mid-operation reset) and a randomized
// run against a slot-level reference model.
module tb_regfile_wb_arbiter;
   import wb_pkg::*;

   localparam int N  = 3;
   localparam int AW = WB_ADDR_W;
   localparam int DW = WB_DATA_W;
   localparam int IW = $clog2(N);

`ifdef WB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [IW-1:0] rf_wsrc;
   logic [AW-1:0] chk_reg1, chk_reg2;
   logic          hazard1, hazard2, busy;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) wb ();

   regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wb       (wb),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .rf_wsrc  (rf_wsrc),
      .chk_reg1 (chk_reg1),
      .chk_reg2 (chk_reg2),
      .hazard1  (hazard1),
      .hazard2  (hazard2),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial if (N < 2 || N > WB_MAX_N_REQ) $fatal(1, "bench N_REQ out of range");

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_all(input logic [N-1:0] v, input logic [AW-1:0] rg, input logic [DW-1:0] d);
      wb.req_valid = v;
      for (int i = 0; i < N; i++) begin
         wb.req_reg[i*AW +: AW]  = rg;
         wb.req_data[i*DW +: DW] = d;
      end
   endtask

   task automatic check_port(input string tag, input logic [N-1:0] rdy, input logic we,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [IW-1:0] ws,
                             input logic h1, input logic h2, input logic bz);
      check({tag, " ready"},   wb.req_ready, rdy);
      check({tag, " rf_we"},   rf_we,        we);
      check({tag, " rf_waddr"}, rf_waddr,    wa);
      check({tag, " rf_wdata"}, rf_wdata,    wd);
      check({tag, " rf_wsrc"}, rf_wsrc,      ws);
      check({tag, " hazard1"}, hazard1,      h1);
      check({tag, " hazard2"}, hazard2,      h2);
      check({tag, " busy"},    busy,         bz);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [N-1:0]  valid;
      logic [AW-1:0] rg;
      logic [DW-1:0] dat;
      logic [AW-1:0] c1;
      logic [AW-1:0] c2;
      logic [N-1:0]  e_ready;
      logic          e_we;
      logic [AW-1:0] e_waddr;
      logic [DW-1:0] e_wdata;
      logic [IW-1:0] e_wsrc;
      logic          e_h1;
      logic          e_h2;
      logic          e_busy;
   } vec_t;

   vec_t vecs [12];

   // Contention: every producer valid on regs 1..N; checks grant order.
   task automatic contention(input string tag);
      int g, src;
      for (int i = 0; i < N; i++) begin
         wb.req_reg[i*AW +: AW]  = AW'(i + 1);
         wb.req_data[i*DW +: DW] = DW'(32'hC0DE_0000 + i);
      end
      wb.req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check($sformatf("%s ready k=%0d", tag, k), wb.req_ready, {N{1'b1}});
         end else begin
            g = RR ? (k - 1) % N : 0;
            check($sformatf("%s ready k=%0d", tag, k), wb.req_ready, N'(1 << g));
         end
         if (k >= 2) begin
            src = RR ? (k - 2) % N : 0;
            check($sformatf("%s rf_we k=%0d", tag, k),    rf_we,    1'b1);
            check($sformatf("%s rf_wsrc k=%0d", tag, k),  rf_wsrc,  IW'(src));
            check($sformatf("%s rf_waddr k=%0d", tag, k), rf_waddr, AW'(src + 1));
            check($sformatf("%s rf_wdata k=%0d", tag, k), rf_wdata, DW'(32'hC0DE_0000 + src));
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- reference model ----------------
   logic          m_v    [N];
   logic [AW-1:0] m_reg  [N];
   logic [DW-1:0] m_data [N];
   logic          m_we;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic [IW-1:0] m_wsrc;
   int            m_last;

   function automatic int pick();
      for (int k = 1; k <= N; k++) begin
         int p;
         p = RR ? (m_last + k) % N : k - 1;
         if (m_v[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic haz(input logic [AW-1:0] r);
      if (r == 0) return 1'b0;
      if (m_we && m_waddr == r) return 1'b1;
      for (int i = 0; i < N; i++) begin
         if (m_v[i] && m_reg[i] == r) return 1'b1;
      end
      return 1'b0;
   endfunction

   initial begin
      logic [AW-1:0] b2b_reg [6];
      logic [N-1:0]  b2b_v   [6];
      logic          cur_v    [N];
      logic [AW-1:0] cur_reg  [N];
      logic [DW-1:0] cur_data [N];
      logic [N-1:0]  prev_ready, exp_ready;
      logic          any_slot;
      int            g;

      reset_n  = 1'b0;
      chk_reg1 = '0;
      chk_reg2 = '0;
      drive_all('0, '0, '0);

      //          valid   rg     dat            c1     c2  | ready   we    waddr  wdata          wsrc   h1    h2    busy
      vecs[0]  = '{3'b000, 5'd0, 32'h0,        5'd0, 5'd0, 3'b111, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{3'b010, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0, 3'b111, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{3'b000, 5'd0, 32'h0,        5'd0, 5'd0, 3'b111, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{3'b000, 5'd0, 32'h0,        5'd0, 5'd0, 3'b111, 1'b1, 5'd7, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{3'b000, 5'd0, 32'h0,        5'd0, 5'd0, 3'b111, 1'b0, 5'd7, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{3'b001, 5'd0, 32'h12345678, 5'd0, 5'd0, 3'b111, 1'b0, 5'd7, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{3'b000, 5'd0, 32'h0,        5'd0, 5'd0, 3'b111, 1'b0, 5'd7, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'b000, 5'd0, 32'h0,        5'd7, 5'd7, 3'b111, 1'b0, 5'd7, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{3'b100, 5'd9, 32'hA5A50009, 5'd9, 5'd0, 3'b111, 1'b0, 5'd7, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{3'b000, 5'd0, 32'h0,        5'd9, 5'd0, 3'b111, 1'b0, 5'd7, 32'hDEADBEEF, 2'd1, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{3'b000, 5'd0, 32'h0,        5'd9, 5'd0, 3'b111, 1'b1, 5'd9, 32'hA5A50009, 2'd2, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{3'b000, 5'd0, 32'h0,        5'd9, 5'd0, 3'b111, 1'b0, 5'd9, 32'hA5A50009, 2'd2, 1'b0, 1'b0, 1'b0};

      // Reset state.
      #12;
      check_port("reset", 3'b000, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single write, register 0 discard, hazard window.
      for (int r = 0; r < 12; r++) begin
         drive_all(vecs[r].valid, vecs[r].rg, vecs[r].dat);
         chk_reg1 = vecs[r].c1;
         chk_reg2 = vecs[r].c2;
         @(negedge clk);
         check_port($sformatf("vec%0d", r), vecs[r].e_ready, vecs[r].e_we, vecs[r].e_waddr,
                    vecs[r].e_wdata, vecs[r].e_wsrc, vecs[r].e_h1, vecs[r].e_h2, vecs[r].e_busy);
         @(posedge clk); #1;
      end
      chk_reg1 = '0;
      chk_reg2 = '0;

      // Contention, then reset with slots full and rf_we high.
      contention("cont1");
      chk_reg1 = 5'd1;
      chk_reg2 = 5'd2;
      reset_n  = 1'b0;
      #2;
      check_port("midreset", 3'b000, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("midreset held ready", wb.req_ready, 3'b000);
      check("midreset held rf_we", rf_we, 1'b0);
      reset_n = 1'b1;
      drive_all('0, '0, '0);
      chk_reg1 = '0;
      chk_reg2 = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("postreset rf_we k=%0d", k), rf_we, 1'b0);
         check($sformatf("postreset busy k=%0d", k),  busy,  1'b0);
         @(posedge clk); #1;
      end
      contention("cont2");

      // Drain, then back-to-back stream from producer 0.
      drive_all('0, '0, '0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      b2b_reg = '{5'd4, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0};
      b2b_v   = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
      for (int b = 0; b < 6; b++) begin
         drive_all(b2b_v[b], b2b_reg[b], DW'(32'h40 + b2b_reg[b]));
         @(negedge clk);
         if (b <= 2) check($sformatf("b2b ready b=%0d", b), wb.req_ready, 3'b111);
         check($sformatf("b2b rf_we b=%0d", b), rf_we, (b >= 2 && b <= 4));
         if (b >= 2 && b <= 4) begin
            check($sformatf("b2b rf_waddr b=%0d", b), rf_waddr, AW'(b + 2));
            check($sformatf("b2b rf_wdata b=%0d", b), rf_wdata, DW'(32'h40 + b + 2));
            check($sformatf("b2b rf_wsrc b=%0d", b),  rf_wsrc,  IW'(0));
         end
         @(posedge clk); #1;
      end

      // Randomized run against the reference model.
      reset_n = 1'b0;
      #2;
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         m_v[i] = 1'b0; m_reg[i] = '0; m_data[i] = '0;
         cur_v[i] = 1'b0; cur_reg[i] = '0; cur_data[i] = '0;
      end
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_wsrc = '0; m_last = N - 1;
      prev_ready = '1;

      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(cur_v[i] && !prev_ready[i])) begin
               cur_v[i]    = ($urandom_range(0, 99) < 60);
               cur_reg[i]  = AW'($urandom_range(0, 7));
               cur_data[i] = $urandom;
            end
            wb.req_valid[i]         = cur_v[i];
            wb.req_reg[i*AW +: AW]  = cur_reg[i];
            wb.req_data[i*DW +: DW] = cur_data[i];
         end
         chk_reg1 = AW'($urandom_range(0, 7));
         chk_reg2 = AW'($urandom_range(0, 7));

         g = pick();
         any_slot = 1'b0;
         for (int i = 0; i < N; i++) begin
            exp_ready[i] = !m_v[i] || (g == i);
            any_slot     = any_slot | m_v[i];
         end

         @(negedge clk);
         check_port($sformatf("rand%0d", c), exp_ready, m_we, m_waddr, m_wdata, m_wsrc,
                    haz(chk_reg1), haz(chk_reg2), any_slot | m_we);

         if (g >= 0) begin
            m_we    = 1'b1;
            m_waddr = m_reg[g];
            m_wdata = m_data[g];
            m_wsrc  = IW'(g);
            m_v[g]  = 1'b0;
            m_last  = g;
         end else begin
            m_we = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (cur_v[i] && exp_ready[i] && cur_reg[i] != 0) begin
               m_v[i]    = 1'b1;
               m_reg[i]  = cur_reg[i];
               m_data[i] = cur_data[i];
            end
         end
         prev_ready = exp_ready;
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the 32x32 register file's single write port. It collects write-back requests from up to N_REQ producers (ALU, load unit, multiplier, ...) over valid/ready handshakes and buffers one entry per producer. Each cycle it grants one buffered entry and drives the register file's RegWrite / write_reg / write_data from registered outputs. It also flags register-read hazards against writes that are still in flight, for the decode stall logic.

## Interface
- N_REQ, 3: number of write-back producers (2..8)
- DATA_W, 32: data width
- ADDR_W, 5: register address width
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  producer i has a write-back
- req_ready  out  N_REQ  arbiter accepts producer i this cycle
- req_reg  in  N_REQ*ADDR_W  destination register; producer i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  write data; producer i at [i*DATA_W +: DATA_W]
- rf_we  out  1  to register file RegWrite
- rf_waddr  out  ADDR_W  to register file write_reg
- rf_wdata  out  DATA_W  to register file write_data
- rf_wsrc  out  $clog2(N_REQ)  index of the producer whose write is on rf_*
- chk_reg1, chk_reg2  in  ADDR_W  registers being read by decode
- hazard1, hazard2  out  1  a pending write targets chk_reg1 / chk_reg2
- busy  out  1  any buffer valid or rf_we high

## Operation
- Per producer: one holding slot (buf_v, buf_reg, buf_data).
- req_ready[i] = !buf_v[i] | grant[i]. A producer can therefore refill on the same edge its slot drains. req_ready is forced to 0 while reset_n is low.
- Handshake: a transfer occurs on a rising edge with req_valid[i] & req_ready[i]. Producers hold reg/data stable while valid & !ready.
- Register 0: an accepted request with req_reg==0 completes its handshake but is discarded. It is never buffered and never reaches rf_*.
- Grant: one-hot over buf_v, combinational, at most one grant per cycle. On the edge, the granted slot goes to rf_waddr/rf_wdata/rf_wsrc and sets rf_we=1. If no slot is valid, rf_we is 0 next cycle and the data outputs hold their value.
- Hazard: hazardN = (chk_regN != 0) & (any buf_v[i] with buf_reg[i]==chk_regN, or rf_we & rf_waddr==chk_regN). The check is combinational.
- Same-register writes from different producers are written in grant order. Producers must not rely on cross-producer ordering.
- Reset (asserted at any time, including mid-operation): all buf_v=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_wsrc=0, round-robin pointer = N_REQ-1. Writes still in flight are lost.

## Timing
- Latency when uncontested: request accepted at edge E0, rf_we=1 after edge E1, register file updated at edge E2.
- Throughput: one register file write per cycle in aggregate. An uncontested producer sustains one request per cycle.
- While contested, a losing producer's slot stays full and its req_ready stays 0 until that slot is granted.
- hazardN asserts in the cycle after acceptance (slot valid). It deasserts the cycle after the register file write edge E2.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - The search starts at (last_grant+1) mod N_REQ.
  - The pointer updates only on a grant.
  - Any continuously pending producer waits at most N_REQ-1 grants.
- WB_RR_EN undefined: fixed priority, index 0 highest. There is no pointer register, and a low-priority producer may starve.

## Structure
- Shared package (wb_pkg): DATA_W/ADDR_W defaults, register count (32), zero-register constant, max N_REQ.
- One sub-module, wb_rr_arbiter: N-way request vector in, one-hot grant plus index out. It holds the round-robin pointer under WB_RR_EN and is pure priority logic otherwise.
- Holding slots, register-0 filter, output register and hazard comparators live in the top module.

## Test plan
- Single write: producer 1 sends reg 7, data 0xDEADBEEF. Expect rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, rf_wsrc=1 one cycle after acceptance, then rf_we=0.
- Zero register: producer 0 sends reg 0, data 0x12345678. The handshake completes, rf_we never asserts, and busy stays 0.
- Contention: all 3 producers valid continuously, regs 1/2/3. With WB_RR_EN, rf_wsrc sequence is 0,1,2,0,1,2. Without it, it is 0,0,0..., and req_ready[1] and req_ready[2] stay 0.
- Hazard: producer 2 writes reg 9 while chk_reg1=9 and chk_reg2=0.
  - hazard1=1 from the cycle after acceptance through the cycle rf_we is high.
  - hazard1=0 afterwards.
  - hazard2 stays 0 throughout.
- Back-to-back: producer 0 streams regs 4,5,6 on consecutive cycles with no competitors. Expect req_ready to stay 1 and rf_waddr to show 4,5,6 on three consecutive cycles.
- Reset mid-operation: with two slots full and rf_we=1, pulse reset_n low. During the low phase, all outputs are 0 and req_ready=0. After release, no stale write appears, and the next contention grants producer 0 first.
